// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared encodings, FSM states and F/D buffer layout for the fetch stage
package fetch_stage_pkg;
  localparam int AW = 16;
  localparam logic [1:0] JS_SEQ = 2'b00;
  localparam logic [1:0] JS_BRANCH = 2'b01;
  localparam logic [1:0] JS_MEM = 2'b10;
  localparam logic [1:0] JS_SEQ_ALT = 2'b11;
  localparam logic [2:0] TWO_WORD_CLASS = 3'b110;
  typedef enum logic [1:0] {S_VEC, S_FETCH, S_IMM} state_e;
  typedef struct packed {
    logic [5:0]    opcode;
    logic [2:0]    src;
    logic [2:0]    dst;
    logic [15:0]   imm;
    logic [AW-1:0] pc_next;
    logic          valid;
    logic          int_out;
  } fd_t;
  localparam fd_t BUBBLE = '0;
  function automatic logic is_two_word(input logic [15:0] w);
    return w[15:13] == TWO_WORD_CLASS;
  endfunction
endpackage

// File: rtl/fd_buffer.sv
// fd_buffer: fetch/decode pipeline register with load enable and synchronous clear
module fd_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_q, data_d;
  always_comb data_d = clr ? '0 : en ? d : data_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) data_q <= '0;
    else data_q <= data_d;
  assign q = data_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, reset vector, two-word assembly and interrupt latch feeding the F/D buffer
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_data,
  input  logic          pc_enable,
  input  logic          f_d_buffer_enable,
  input  logic          flush,
  input  logic [1:0]    jump_sel,
  input  logic [AW-1:0] branch_target,
  input  logic [AW-1:0] mem_target,
  input  logic          interrupt,
  output logic [5:0]    opcode,
  output logic [2:0]    src,
  output logic [2:0]    dst,
  output logic [15:0]   imm,
  output logic [AW-1:0] pc_next,
  output logic          valid,
  output logic          int_out
);
  state_e state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_inc, target;
  logic [15:0] hold_q, hold_d;
  logic pending_q, pending_d, redirect, consume;
  fd_t fd_d, fd_q;
  always_comb begin
    pc_inc = pc_q + 1'b1;
    imem_addr = state_q == S_VEC ? '0 : pc_q;
    redirect = pc_enable && state_q != S_VEC && (jump_sel == JS_BRANCH || jump_sel == JS_MEM);
    target = jump_sel == JS_BRANCH ? branch_target : mem_target;
    state_d = state_q;
    pc_d = pc_q;
    hold_d = hold_q;
    fd_d = BUBBLE;
    if (redirect) begin
      pc_d = target;
      state_d = S_FETCH;
    end else if (pc_enable) begin
      case (state_q)
        S_VEC: begin
          pc_d = imem_data;
          state_d = S_FETCH;
        end
        S_FETCH: begin
          pc_d = pc_inc;
          if (is_two_word(imem_data)) begin
            hold_d = imem_data;
            state_d = S_IMM;
          end else fd_d = '{imem_data[15:10], imem_data[9:7], imem_data[6:4], 16'h0, pc_inc, 1'b1, 1'b0};
        end
        default: begin
          pc_d = pc_inc;
          state_d = S_FETCH;
          fd_d = '{hold_q[15:10], hold_q[9:7], hold_q[6:4], imem_data, pc_inc, 1'b1, 1'b0};
        end
      endcase
    end
    // interrupts ride only on completed instructions, so never between two words
    consume = fd_d.valid && f_d_buffer_enable && !flush;
    fd_d.int_out = consume && pending_q;
    pending_d = interrupt || (pending_q && !consume);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_VEC;
      pc_q <= '0;
      hold_q <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      hold_q <= hold_d;
      pending_q <= pending_d;
    end
  fd_buffer #(.W($bits(fd_t))) u_fd_buffer (
    .clk(clk),
    .rst(rst),
    .en(f_d_buffer_enable),
    .clr(flush),
    .d(fd_d),
    .q(fd_q)
  );
  assign opcode = fd_q.opcode;
  assign src = fd_q.src;
  assign dst = fd_q.dst;
  assign imm = fd_q.imm;
  assign pc_next = fd_q.pc_next;
  assign valid = fd_q.valid;
  assign int_out = fd_q.int_out;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plan plus randomized run against an instruction-level reference model
module tb_fetch_stage;
  typedef struct packed {
    logic [5:0]  op;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [15:0] imm;
    logic [15:0] pcn;
    logic        valid;
    logic        intr;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] imem_addr, imem_data, branch_target, mem_target, pc_next, imm;
  logic pc_enable, f_d_buffer_enable, flush, interrupt, valid, int_out;
  logic [1:0] jump_sel;
  logic [5:0] opcode;
  logic [2:0] src, dst;
  logic [15:0] mem [65536];
  int n_cmp = 0;
  int n_err = 0;
  int mode;
  logic [15:0] mpc, mhold;
  bit mpend;
  exp_t ex;
  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];
  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .pc_enable(pc_enable),
    .f_d_buffer_enable(f_d_buffer_enable),
    .flush(flush),
    .jump_sel(jump_sel),
    .branch_target(branch_target),
    .mem_target(mem_target),
    .interrupt(interrupt),
    .opcode(opcode),
    .src(src),
    .dst(dst),
    .imm(imm),
    .pc_next(pc_next),
    .valid(valid),
    .int_out(int_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    mode = 0;
    mpc = '0;
    mhold = '0;
    mpend = 0;
    ex = '0;
  endtask
  // mode 0: fetching reset vector, 1: expecting an instruction start, 2: expecting an immediate word
  task automatic model_step();
    logic [15:0] w, first;
    bit cons;
    exp_t n;
    w = mem[mode == 0 ? 16'h0 : mpc];
    n = '0;
    if (pc_enable && mode != 0 && (jump_sel == 2'd1 || jump_sel == 2'd2)) begin
      mpc = jump_sel == 2'd1 ? branch_target : mem_target;
      mode = 1;
    end else if (pc_enable) begin
      if (mode == 0) begin
        mpc = w;
        mode = 1;
      end else if (mode == 1 && w[15:13] == 3'b110) begin
        mhold = w;
        mpc = 16'(mpc + 1);
        mode = 2;
      end else begin
        first = mode == 2 ? mhold : w;
        n.op = first[15:10];
        n.src = first[9:7];
        n.dst = first[6:4];
        n.imm = mode == 2 ? w : 16'h0;
        n.pcn = 16'(mpc + 1);
        n.valid = 1'b1;
        mpc = 16'(mpc + 1);
        mode = 1;
      end
    end
    cons = n.valid && f_d_buffer_enable && !flush;
    n.intr = cons && mpend;
    if (flush) ex = '0;
    else if (f_d_buffer_enable) ex = n;
    mpend = interrupt || (mpend && !cons);
  endtask
  task automatic cmp_all();
    chk("opcode", opcode, ex.op);
    chk("src", src, ex.src);
    chk("dst", dst, ex.dst);
    chk("imm", imm, ex.imm);
    chk("pc_next", pc_next, ex.pcn);
    chk("valid", valid, ex.valid);
    chk("int_out", int_out, ex.intr);
  endtask
  task automatic tick(input logic pe, input logic fde, input logic fl, input logic [1:0] js,
                      input logic [15:0] bt, input logic [15:0] mt, input logic irq);
    pc_enable = pe;
    f_d_buffer_enable = fde;
    flush = fl;
    jump_sel = js;
    branch_target = bt;
    mem_target = mt;
    interrupt = irq;
    @(negedge clk);
    chk("imem_addr", imem_addr, mode == 0 ? 16'h0 : mpc);
    model_step();
    @(posedge clk);
    #1;
    cmp_all();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1, 1, 0, 2'd0, 16'h0, 16'h0, 0);
  endtask
  // called just after a rising edge; outputs must clear before the next edge
  task automatic do_rst();
    rst = 1'b1;
    #1;
    model_reset();
    cmp_all();
    chk("rst_addr", imem_addr, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    pc_enable = 1;
    f_d_buffer_enable = 1;
    flush = 0;
    jump_sel = 2'd0;
    branch_target = '0;
    mem_target = '0;
    interrupt = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h0000] = 16'h0040;
    mem[16'h0040] = 16'h0400;
    mem[16'h0041] = 16'hC400;
    mem[16'h0042] = 16'hBEEF;
    mem[16'h0043] = 16'h0800;
    mem[16'h0044] = 16'hC400;
    mem[16'h0045] = 16'h1234;
    mem[16'h0100] = 16'h0C00;
    mem[16'h0101] = 16'hC400;
    mem[16'h0102] = 16'h5555;
    mem[16'h0103] = 16'h1000;
    mem[16'h0104] = 16'h1400;
    mem[16'hFFFF] = 16'h1800;
    model_reset();
    #1;
    cmp_all();
    chk("rst_addr", imem_addr, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(1);
    chk("vec_pc", imem_addr, 16'h0040);
    chk("vec_bubble", valid, 1'b0);
    run(1);
    chk("first_op", opcode, 6'h01);
    chk("first_valid", valid, 1'b1);
    chk("first_pcn", pc_next, 16'h0041);
    run(1);
    chk("two_bubble", valid, 1'b0);
    run(1);
    chk("two_op", opcode, 6'b110001);
    chk("two_imm", imm, 16'hBEEF);
    chk("two_pcn", pc_next, 16'h0043);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 2'd0, 16'h0, 16'h0, 0);
    chk("stall_op", opcode, 6'b110001);
    chk("stall_pc", imem_addr, 16'h0043);
    tick(1, 1, 1, 2'd0, 16'h0, 16'h0, 0);
    chk("flush_valid", valid, 1'b0);
    chk("flush_op", opcode, 6'h00);
    chk("flush_pcn", pc_next, 16'h0000);
    run(1);
    tick(1, 1, 0, 2'd1, 16'h0100, 16'h0, 0);
    chk("redir_valid", valid, 1'b0);
    chk("redir_pc", imem_addr, 16'h0100);
    run(1);
    chk("redir_op", opcode, 6'h03);
    chk("redir_imm", imm, 16'h0000);
    chk("redir_pcn", pc_next, 16'h0101);
    run(1);
    tick(1, 1, 0, 2'd0, 16'h0, 16'h0, 1);
    chk("irq_two_imm", imm, 16'h5555);
    chk("irq_two_int", int_out, 1'b0);
    run(1);
    chk("irq_next_op", opcode, 6'h04);
    chk("irq_next_int", int_out, 1'b1);
    run(1);
    chk("irq_after_int", int_out, 1'b0);
    tick(1, 1, 0, 2'd2, 16'h0, 16'hFFFF, 0);
    chk("wrap_bubble", valid, 1'b0);
    run(1);
    chk("wrap_op", opcode, 6'h06);
    chk("wrap_pcn", pc_next, 16'h0000);
    chk("wrap_pc", imem_addr, 16'h0000);
    do_rst();
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) do_rst();
      else begin
        logic en;
        en = $urandom_range(3) != 0;
        tick(en, en, $urandom_range(7) == 0,
             $urandom_range(5) == 0 ? 2'($urandom) : 2'd0,
             16'($urandom), 16'($urandom), $urandom_range(9) == 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
